// File: rtl/stepmotor_pkg.sv
// Shared definitions for the stepper schedule controller: schedule states,
// winding phase table and LED status patterns.
package stepmotor_pkg;

    typedef enum logic [1:0] {
        FWD   = 2'b00,
        STOP1 = 2'b01,
        REV   = 2'b10,
        STOP2 = 2'b11
    } sched_state_t;

    // Half-step sequence; odd entries are the two-phase-on full-step patterns.
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    localparam logic [5:0] LED_FWD  = 6'b000111;
    localparam logic [5:0] LED_REV  = 6'b111000;
    localparam logic [5:0] LED_STOP = 6'b000000;

    function automatic sched_state_t next_sched(input sched_state_t s);
        sched_state_t n;
        case (s)
            FWD:     n = STOP1;
            STOP1:   n = REV;
            REV:     n = STOP2;
            default: n = FWD;
        endcase
        return n;
    endfunction

    function automatic logic [5:0] led_for(input sched_state_t s);
        logic [5:0] l;
        case (s)
            FWD:     l = LED_FWD;
            REV:     l = LED_REV;
            default: l = LED_STOP;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/stepmotor_seq_tick_gen.sv
// Free-running prescaler that emits a one-cycle enable on its terminal count;
// the count freezes while en is low so a pause resumes mid-interval.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_reg;

    assign tick = en && (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + W'(1);
        end
    end

endmodule

// File: rtl/stepmotor_seq.sv
// Four-phase unipolar stepper sequencer running a forward/stop/reverse/stop
// schedule with full- or half-step drive and an RGB status field.
module stepmotor_seq
    import stepmotor_pkg::*;
#(
    parameter int SEC_DIV  = 12000000,
    parameter int STEP_DIV = 12000,
    parameter int T_FWD    = 30,
    parameter int T_STOP   = 10,
    parameter int T_REV    = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       half_step,
    output logic [3:0] phase,
    output logic [5:0] led,
    output logic [1:0] state,
    output logic [5:0] sec_left
);

    localparam int TICK_DIV [2] = '{SEC_DIV, STEP_DIV};
    localparam logic [5:0] DUR_FWD  = 6'(T_FWD);
    localparam logic [5:0] DUR_STOP = 6'(T_STOP);
    localparam logic [5:0] DUR_REV  = 6'(T_REV);

    logic [1:0]   ticks;
    logic         sec_tick;
    logic         step_tick;

    sched_state_t state_reg, state_next;
    logic [5:0]   sec_left_reg, sec_left_next;
    logic [2:0]   idx_reg, idx_next;
    logic [2:0]   step_amt;
    logic [3:0]   phase_reg;
    logic [5:0]   led_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tick
            tick_gen #(.DIV(TICK_DIV[gi])) u_tick (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .tick (ticks[gi])
            );
        end
    endgenerate

    assign sec_tick  = ticks[0];
    assign step_tick = ticks[1];

    // Full-step from an odd index jumps two entries to stay on two-phase-on.
    assign step_amt = (half_step || !idx_reg[0]) ? 3'd1 : 3'd2;

    always_comb begin
        state_next    = state_reg;
        sec_left_next = sec_left_reg;
        if (sec_tick) begin
            if (sec_left_reg == 6'd1) begin
                state_next = next_sched(state_reg);
                case (state_next)
                    FWD:     sec_left_next = DUR_FWD;
                    REV:     sec_left_next = DUR_REV;
                    default: sec_left_next = DUR_STOP;
                endcase
            end else begin
                sec_left_next = sec_left_reg - 6'd1;
            end
        end
    end

    // Direction comes from the pre-transition state on a coincident sec_tick.
    always_comb begin
        idx_next = idx_reg;
        if (step_tick) begin
            case (state_reg)
                FWD:     idx_next = idx_reg + step_amt;
                REV:     idx_next = idx_reg - step_amt;
                default: idx_next = idx_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= FWD;
            sec_left_reg <= DUR_FWD;
            idx_reg      <= 3'd0;
            phase_reg    <= 4'b0000;
            led_reg      <= LED_FWD;
        end else begin
            state_reg    <= state_next;
            sec_left_reg <= sec_left_next;
            idx_reg      <= idx_next;
            phase_reg    <= (en && (state_reg == FWD || state_reg == REV))
                            ? PHASE_TABLE[idx_reg] : 4'b0000;
            led_reg      <= led_for(state_reg);
        end
    end

    assign phase    = phase_reg;
    assign led      = led_reg;
    assign state    = state_reg;
    assign sec_left = sec_left_reg;

endmodule

// File: tb/tb_stepmotor_seq.sv
// Randomized bench for stepmotor_seq against a schedule model derived from
// the count of enabled cycles since reset.
module tb_stepmotor_seq;

    localparam int SEC_DIV  = 20;
    localparam int STEP_DIV = 4;
    localparam int T_FWD    = 3;
    localparam int T_STOP   = 2;
    localparam int T_REV    = 3;
    localparam int PERIOD   = T_FWD + T_STOP + T_REV + T_STOP;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       half_step;
    logic [3:0] phase;
    logic [5:0] led;
    logic [1:0] state;
    logic [5:0] sec_left;

    stepmotor_seq #(
        .SEC_DIV  (SEC_DIV),
        .STEP_DIV (STEP_DIV),
        .T_FWD    (T_FWD),
        .T_STOP   (T_STOP),
        .T_REV    (T_REV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .half_step (half_step),
        .phase     (phase),
        .led       (led),
        .state     (state),
        .sec_left  (sec_left)
    );

    always #5 clk = ~clk;

    int         checks_total  = 0;
    int         checks_passed = 0;
    logic [3:0] phase_tbl [8];
    int         m_active;
    int         m_idx;
    int         last_state = -1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // Schedule position from the number of whole seconds elapsed (0=FWD..3=STOP2).
    function automatic void sched(input int secs, output int st, output int left);
        int p;
        p = secs % PERIOD;
        if (p < T_FWD) begin
            st = 0; left = T_FWD - p;
        end else if (p < T_FWD + T_STOP) begin
            st = 1; left = T_FWD + T_STOP - p;
        end else if (p < T_FWD + T_STOP + T_REV) begin
            st = 2; left = T_FWD + T_STOP + T_REV - p;
        end else begin
            st = 3; left = PERIOD - p;
        end
    endfunction

    function automatic logic [5:0] led_model(input int st);
        if (st == 0) return 6'b000111;
        if (st == 2) return 6'b111000;
        return 6'b000000;
    endfunction

    task automatic step_cycle(input logic r, input logic e, input logic h);
        int st_pre, left_pre, st_post, left_post, amt;
        logic [3:0] exp_phase;
        logic [5:0] exp_led;
        rst = r; en = e; half_step = h;
        sched(m_active / SEC_DIV, st_pre, left_pre);
        exp_led   = led_model(st_pre);
        exp_phase = (e && (st_pre == 0 || st_pre == 2)) ? phase_tbl[m_idx] : 4'b0000;
        if (!r) begin
            m_active  = 0;
            m_idx     = 0;
            exp_phase = 4'b0000;
            exp_led   = 6'b000111;
        end else if (e) begin
            if (m_active % STEP_DIV == STEP_DIV - 1) begin
                amt = (h || (m_idx % 2 == 0)) ? 1 : 2;
                if (st_pre == 0) m_idx = (m_idx + amt) % 8;
                else if (st_pre == 2) m_idx = (m_idx + 8 - amt) % 8;
            end
            m_active++;
        end
        sched(m_active / SEC_DIV, st_post, left_post);
        @(posedge clk);
        #1;
        check("state",    8'(state),    8'(st_post));
        check("sec_left", 8'(sec_left), 8'(left_post));
        check("phase",    8'(phase),    8'(exp_phase));
        check("led",      8'(led),      8'(exp_led));
        if (st_post != last_state) begin
            $display("t=%0t state=%0d sec_left=%0d phase=%b led=%b", $time, state, sec_left, phase, led);
            last_state = st_post;
        end
    endtask

    task automatic run(input int n, input logic e, input logic h);
        for (int i = 0; i < n; i++) step_cycle(1'b1, e, h);
    endtask

    initial begin
        logic [3:0] init_tbl [8];
        logic       r_e, r_h;
        init_tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
        phase_tbl = init_tbl;
        m_active = 0;
        m_idx    = 0;
        rst = 1'b0; en = 1'b0; half_step = 1'b0;

        // Reset, then a full half-step schedule and into the next FWD.
        for (int i = 0; i < 3; i++) step_cycle(1'b0, 1'b0, 1'b1);
        run(220, 1'b1, 1'b1);

        // Full-step through forward and reverse.
        for (int i = 0; i < 2; i++) step_cycle(1'b0, 1'b1, 1'b0);
        run(210, 1'b1, 1'b0);

        // Pause mid-FWD, then resume.
        step_cycle(1'b0, 1'b1, 1'b1);
        run(30, 1'b1, 1'b1);
        run(50, 1'b0, 1'b1);
        run(60, 1'b1, 1'b1);

        // Reset landing on a REV step tick, then resume.
        step_cycle(1'b0, 1'b1, 1'b1);
        run(143, 1'b1, 1'b1);
        step_cycle(1'b0, 1'b1, 1'b1);
        run(20, 1'b1, 1'b0);

        // Random enable/mode/reset traffic.
        r_e = 1'b1; r_h = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) r_e = ~r_e;
            if ($urandom_range(0, 29) == 0) r_h = ~r_h;
            step_cycle(($urandom_range(0, 299) != 0), r_e, r_h);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
